// File: rtl/spi_weight_loader_pkg.sv
// spi_weight_loader_pkg: shared FSM states, SPI read opcode, word-phase encoding and header byte select
package spi_weight_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_CMD,
        S_ADDR,
        S_DATA,
        S_DONE,
        S_GAP
    } state_e;

    localparam logic [7:0] SPI_READ_CMD = 8'h03;

    localparam logic PHASE_HI = 1'b0;
    localparam logic PHASE_LO = 1'b1;

    // Next byte to put on MOSI; cnt is the number of header bits still to go in the current state.
    function automatic logic [7:0] hdr_byte(input state_e s, input logic [23:0] adr,
                                            input logic [31:0] cnt, input logic [7:0] cmd);
        return s == S_CLR ? cmd :
               s == S_CMD ? adr[23:16] :
               s == S_ADDR && cnt > 32'd16 ? adr[15:8] :
               s == S_ADDR && cnt > 32'd8 ? adr[7:0] : 8'h00;
    endfunction

endpackage

// File: rtl/spi_weight_loader_shift_engine.sv
// spi_weight_loader_shift_engine: SCK divider plus 8-bit SPI shifter, mode 0, MSB first
// Ports: clk_i/rst_ni clock and async active-low reset; go_i runs SCK (low and reset while 0);
//        load_i/tx_byte_i load the transmit byte; bit_done_o pulses on each SCK fall;
//        rx_byte_o holds the sampled byte, byte_done_o pulses the cycle after its 8th sample;
//        sck_o/mosi_o/miso_i are the SPI pins.
module spi_weight_loader_shift_engine #(
    parameter int CLK_DIV = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       go_i,
    input  logic       load_i,
    input  logic [7:0] tx_byte_i,
    input  logic       miso_i,
    output logic       bit_done_o,
    output logic       byte_done_o,
    output logic [7:0] rx_byte_o,
    output logic       sck_o,
    output logic       mosi_o
);
    localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_q, div_d;
    logic [2:0]    bits_q, bits_d;
    logic [7:0]    tx_q, tx_d, rx_q, rx_d;
    logic          sck_q, sck_d, done_q, done_d;
    logic          tick, rise, fall;

    assign tick = go_i && div_q == '0;
    assign rise = tick && !sck_q;
    assign fall = tick && sck_q;

    always_comb begin
        div_d  = go_i && !tick ? div_q - DW'(1) : DIV_MAX;
        sck_d  = go_i && (sck_q ^ tick);
        bits_d = go_i ? bits_q + 3'(fall) : 3'd0;
        rx_d   = rise ? {rx_q[6:0], miso_i} : rx_q;
        // at a byte boundary the falling edge reloads, so the next MSB appears without a gap
        tx_d   = load_i || (fall && bits_q == 3'd7) ? tx_byte_i :
                 fall ? {tx_q[6:0], 1'b0} : tx_q;
        done_d = rise && bits_q == 3'd7;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_q  <= DIV_MAX;
            bits_q <= 3'd0;
            tx_q   <= 8'h00;
            rx_q   <= 8'h00;
            sck_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            bits_q <= bits_d;
            tx_q   <= tx_d;
            rx_q   <= rx_d;
            sck_q  <= sck_d;
            done_q <= done_d;
        end
    end

    assign bit_done_o  = fall;
    assign byte_done_o = done_q;
    assign rx_byte_o   = rx_q;
    assign sck_o       = sck_q;
    assign mosi_o      = tx_q[7];

endmodule

// File: rtl/spi_weight_loader.sv
// spi_weight_loader: SPI-flash read master streaming bytes into 16-bit SNN weight words
// Ports: i_wb_clk/i_wb_rst_n clock and async active-low reset; i_start request level with
//        i_adr/i_siz (bits) sampled at job start; o_dat/o_load1/o_load2/o_snn_we deliver byte pairs;
//        o_clr/o_set0 mark job start/end; o_busy spans the job; o_sck/o_cs_n/o_mosi/i_miso flash pins.
module spi_weight_loader
    import spi_weight_loader_pkg::*;
#(
    parameter int         CLK_DIV  = 2,
    parameter logic [7:0] READ_CMD = SPI_READ_CMD,
    parameter int         CS_GAP   = 2
) (
    input  logic        i_wb_clk,
    input  logic        i_wb_rst_n,
    input  logic        i_start,
    input  logic [23:0] i_adr,
    input  logic [31:0] i_siz,
    output logic [7:0]  o_dat,
    output logic        o_load1,
    output logic        o_load2,
    output logic        o_snn_we,
    output logic        o_clr,
    output logic        o_set0,
    output logic        o_busy,
    output logic        o_sck,
    output logic        o_cs_n,
    output logic        o_mosi,
    input  logic        i_miso
);
    localparam logic [7:0] GAP_INIT = 8'(CS_GAP - 1);

    state_e      state_q, state_d;
    logic        start_q;
    logic [23:0] adr_q, adr_d;
    logic [31:0] siz_q, siz_d, cnt_q, cnt_d;
    logic [7:0]  dat_q, dat_d, gap_q, gap_d;
    logic        phase_q, phase_d, fin_q, fin_d;
    logic        load1_q, load1_d, load2_q, load2_d, we_q;
    logic        shifting, go, bit_done, byte_done, eng_mosi;
    logic [7:0]  rx_byte;

    assign shifting = state_q == S_CMD || state_q == S_ADDR || state_q == S_DATA;
    // stop SCK once the last data bit has been clocked so no extra pulse precedes DONE
    assign go = shifting && !(state_q == S_DATA && cnt_q == 32'd0);

    spi_weight_loader_shift_engine #(.CLK_DIV(CLK_DIV)) u_eng (
        .clk_i      (i_wb_clk),
        .rst_ni     (i_wb_rst_n),
        .go_i       (go),
        .load_i     (state_q == S_CLR),
        .tx_byte_i  (hdr_byte(state_q, adr_q, cnt_q, READ_CMD)),
        .miso_i     (i_miso),
        .bit_done_o (bit_done),
        .byte_done_o(byte_done),
        .rx_byte_o  (rx_byte),
        .sck_o      (o_sck),
        .mosi_o     (eng_mosi)
    );

    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        siz_d   = siz_q;
        cnt_d   = cnt_q;
        dat_d   = dat_q;
        gap_d   = gap_q;
        phase_d = phase_q;
        fin_d   = fin_q;
        load1_d = 1'b0;
        load2_d = 1'b0;
        unique case (state_q)
            S_IDLE: state_d = i_start && !start_q ? S_CLR : S_IDLE;
            S_CLR: begin
                adr_d   = i_adr;
                siz_d   = i_siz;
                cnt_d   = 32'd8;
                phase_d = PHASE_HI;
                fin_d   = 1'b0;
                state_d = i_siz == 32'd0 ? S_DONE : S_CMD;
            end
            S_CMD: if (bit_done) begin
                cnt_d   = cnt_q == 32'd1 ? 32'd24 : cnt_q - 32'd1;
                state_d = cnt_q == 32'd1 ? S_ADDR : S_CMD;
            end
            S_ADDR: if (bit_done) begin
                cnt_d   = cnt_q == 32'd1 ? siz_q : cnt_q - 32'd1;
                state_d = cnt_q == 32'd1 ? S_DATA : S_ADDR;
            end
            S_DATA: begin
                cnt_d = bit_done ? cnt_q - 32'd1 : cnt_q;
                if (byte_done) begin
                    dat_d   = rx_byte;
                    load1_d = phase_q == PHASE_HI;
                    load2_d = phase_q == PHASE_LO;
                    phase_d = ~phase_q;
                    // the byte's final bit is not yet counted, so one bit left means last byte
                    fin_d   = cnt_q == 32'd1;
                end
                // leave after the last strobe: lone load1, or the write that follows load2
                state_d = fin_q && (load1_q || we_q) ? S_DONE : S_DATA;
            end
            S_DONE: begin
                gap_d   = GAP_INIT;
                state_d = S_GAP;
            end
            S_GAP: begin
                gap_d   = gap_q - 8'd1;
                state_d = gap_q == 8'd0 ? S_IDLE : S_GAP;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
        if (!i_wb_rst_n) begin
            state_q <= S_IDLE;
            start_q <= 1'b0;
            adr_q   <= 24'h0;
            siz_q   <= 32'h0;
            cnt_q   <= 32'h0;
            dat_q   <= 8'h00;
            gap_q   <= 8'h00;
            phase_q <= PHASE_HI;
            fin_q   <= 1'b0;
            load1_q <= 1'b0;
            load2_q <= 1'b0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= i_start;
            adr_q   <= adr_d;
            siz_q   <= siz_d;
            cnt_q   <= cnt_d;
            dat_q   <= dat_d;
            gap_q   <= gap_d;
            phase_q <= phase_d;
            fin_q   <= fin_d;
            load1_q <= load1_d;
            load2_q <= load2_d;
            we_q    <= load2_q;
        end
    end

    assign o_dat    = dat_q;
    assign o_load1  = load1_q;
    assign o_load2  = load2_q;
    assign o_snn_we = we_q;
    assign o_clr    = state_q == S_CLR;
    assign o_set0   = state_q == S_DONE;
    assign o_busy   = state_q != S_IDLE && state_q != S_GAP;
    assign o_cs_n   = !shifting;
    assign o_mosi   = shifting && eng_mosi;

endmodule
